// File: rtl/svm_seq_mac_pkg.sv
// Shared widths, state encoding and accumulator sizing for the sequential SVM engine.
package svm_pkg;

  localparam int N_FEATURES    = 21;
  localparam int FEATURE_WIDTH = 4;
  localparam int WEIGHT_WIDTH  = 8;
  localparam int BIAS_WIDTH    = 16;

  // Worst-case sum of n products plus bias, with one guard bit for the sign.
  function automatic int calc_acc_w(input int n, input int fw, input int ww, input int bw);
    int prod_sum_w;
    prod_sum_w = fw + 1 + ww + $clog2(n);
    return ((bw > prod_sum_w) ? bw : prod_sum_w) + 1;
  endfunction

  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ACC_W = calc_acc_w(N_FEATURES, FEATURE_WIDTH, WEIGHT_WIDTH, BIAS_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2,
    GAP  = 2'd3
  } svm_state_t;

  typedef logic signed [ACC_W-1:0] acc_t;

endpackage

// File: rtl/svm_seq_mac_if.sv
// Feature/weight/result bundle between the SVM class picker (master) and the engine (slave).
interface svm_seq_mac_if
  import svm_pkg::*;
#(
  parameter int N_features   = N_FEATURES,
  parameter int featureWidth = FEATURE_WIDTH,
  parameter int weightWidth  = WEIGHT_WIDTH,
  parameter int biasWidth    = BIAS_WIDTH
) ();

  localparam int ACC_W_L = calc_acc_w(N_features, featureWidth, weightWidth, biasWidth);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [featureWidth*N_features-1:0]   features;
  logic [weightWidth*N_features-1:0]    weight;
  logic [biasWidth-1:0]                 bia;
  logic                                 svmready;
  logic                                 w_class;
  logic [ACC_W_L-1:0]                   score;

  modport master (
    output in_valid, features, weight, bia,
    input  in_ready, svmready, w_class, score
  );

  modport slave (
    input  in_valid, features, weight, bia,
    output in_ready, svmready, w_class, score
  );

endinterface

// File: rtl/svm_mac_step.sv
// One multiply-accumulate step: selects feature/weight idx and adds their signed product to acc.
module svm_mac_step #(
  parameter int N_features   = 21,
  parameter int featureWidth = 4,
  parameter int weightWidth  = 8,
  parameter int ACC_W        = 19,
  parameter int IDX_W        = 5
) (
  input  logic [featureWidth*N_features-1:0] features,
  input  logic [weightWidth*N_features-1:0]  weight,
  input  logic [IDX_W-1:0]                   idx,
  input  logic signed [ACC_W-1:0]            acc,
  output logic signed [ACC_W-1:0]            acc_next
);

  localparam int PROD_W = featureWidth + weightWidth + 1;

  logic [featureWidth-1:0]       f_sel;
  logic signed [weightWidth-1:0] w_sel;
  logic signed [PROD_W-1:0]      prod;

  assign f_sel = features[idx*featureWidth +: featureWidth];
  assign w_sel = weight[idx*weightWidth +: weightWidth];

  // Features are unsigned, so a zero MSB keeps them positive in the signed multiply.
  assign prod     = $signed({1'b0, f_sel}) * w_sel;
  assign acc_next = acc + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});

endmodule

// File: rtl/svm_seq_mac.sv
// Sequential one-vs-one SVM engine: latches a feature vector, then runs two
// decision passes (one feature per cycle) against the picker's current weight set.
module svm_seq_mac
  import svm_pkg::*;
#(
  parameter int N_features   = N_FEATURES,
  parameter int featureWidth = FEATURE_WIDTH,
  parameter int weightWidth  = WEIGHT_WIDTH,
  parameter int biasWidth    = BIAS_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  svm_seq_mac_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for a feature vector, in_ready high
  // ACC   | one multiply-accumulate per cycle over all features
  // DONE  | pass result on svmready/w_class/score; restart for pass 1 or finish
  // GAP   | one idle cycle matching the picker's final state

  localparam int ACC_W = calc_acc_w(N_features, featureWidth, weightWidth, biasWidth);
  localparam int IDX_W = calc_idx_w(N_features);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_features - 1);

  svm_state_t                         state;
  logic                               pass;
  logic [IDX_W-1:0]                   idx;
  logic signed [ACC_W-1:0]            acc;
  logic signed [ACC_W-1:0]            acc_next;
  logic signed [ACC_W-1:0]            bia_ext;
  logic [featureWidth*N_features-1:0] feat_q;
  logic                               svmready_q;
  logic                               w_class_q;
  logic [ACC_W-1:0]                   score_q;

  assign bia_ext = $signed({{(ACC_W-biasWidth){bus.bia[biasWidth-1]}}, bus.bia});

  svm_mac_step #(
    .N_features   (N_features),
    .featureWidth (featureWidth),
    .weightWidth  (weightWidth),
    .ACC_W        (ACC_W),
    .IDX_W        (IDX_W)
  ) u_step (
    .features (feat_q),
    .weight   (bus.weight),
    .idx      (idx),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pass       <= 1'b0;
      idx        <= '0;
      acc        <= '0;
      feat_q     <= '0;
      svmready_q <= 1'b0;
      w_class_q  <= 1'b0;
      score_q    <= '0;
    end else begin
      svmready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            feat_q <= bus.features;
            pass   <= 1'b0;
            idx    <= '0;
            acc    <= bia_ext;
            state  <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          if (idx == IDX_LAST) begin
            // Outputs are loaded on entry so they are valid for exactly the DONE cycle.
            svmready_q <= 1'b1;
            w_class_q  <= acc_next[ACC_W-1];
            score_q    <= acc_next;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (!pass) begin
            pass  <= 1'b1;
            idx   <= '0;
            acc   <= bia_ext;
            state <= ACC;
          end else begin
            state <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == IDLE);
  assign bus.svmready = svmready_q;
  assign bus.w_class  = w_class_q;
  assign bus.score    = score_q;

endmodule

// File: tb/tb_svm_seq_mac.sv
// Directed bench for svm_seq_mac at N_features=4 with a small picker model swapping weight sets on svmready.
module tb_svm_seq_mac;

  localparam int N  = 4;
  localparam int FW = 4;
  localparam int WW = 8;
  localparam int BW = 16;
  localparam int AW = 17;

  typedef struct {
    logic [FW*N-1:0] x;
    logic [WW*N-1:0] w0;
    logic [BW-1:0]   b0;
    logic [WW*N-1:0] w1;
    logic [BW-1:0]   b1;
    int              s0;
    int              s1;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[4];

  svm_seq_mac_if #(.N_features(N), .featureWidth(FW), .weightWidth(WW), .biasWidth(BW)) bus ();

  svm_seq_mac #(.N_features(N), .featureWidth(FW), .weightWidth(WW), .biasWidth(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint score_s();
    logic signed [AW-1:0] s;
    s = bus.score;
    return longint'(s);
  endfunction

  // Drives one vector, follows both passes and returns at the negedge where in_ready is expected back.
  task automatic do_vec(input vec_t v, input bit keep_valid, input string tag);
    bit got;
    int first_sv;
    int second_sv;
    int n_sv;
    int busy_bad;
    @(negedge clk);
    bus.features = v.x;
    bus.weight   = v.w0;
    bus.bia      = v.b0;
    bus.in_valid = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " accept"}, longint'(got), 1);
    if (!got) return;
    @(posedge clk);
    first_sv  = -1;
    second_sv = -1;
    n_sv      = 0;
    busy_bad  = 0;
    for (int k = 1; k <= 2*N+4; k++) begin
      @(negedge clk);
      if (!keep_valid) bus.in_valid = 1'b0;
      if (bus.svmready) begin
        n_sv++;
        if (first_sv < 0) begin
          first_sv = k;
          chk({tag, " score0"}, score_s(), longint'(v.s0));
          chk({tag, " w_class0"}, longint'(bus.w_class), (v.s0 < 0) ? 1 : 0);
          bus.weight = v.w1;
          bus.bia    = v.b1;
        end else if (second_sv < 0) begin
          second_sv = k;
          chk({tag, " score1"}, score_s(), longint'(v.s1));
          chk({tag, " w_class1"}, longint'(bus.w_class), (v.s1 < 0) ? 1 : 0);
        end
      end
      if (k < 2*N+4 && bus.in_ready) busy_bad++;
    end
    chk({tag, " pass0 cycle"}, longint'(first_sv), N+1);
    chk({tag, " pass1 cycle"}, longint'(second_sv), 2*N+2);
    chk({tag, " svmready pulses"}, longint'(n_sv), 2);
    chk({tag, " busy in_ready"}, longint'(busy_bad), 0);
    chk({tag, " in_ready back"}, longint'(bus.in_ready), 1);
    chk({tag, " w_class held"}, longint'(bus.w_class), (v.s1 < 0) ? 1 : 0);
  endtask

  initial begin
    int n_sv;
    n_tests = 0;
    n_fail  = 0;

    // x={1,1,1,1}: pass0 w=1,b=-5 -> -1; pass1 w=2,b=0 -> 8
    vecs[0] = '{16'h1111, 32'h01010101, 16'hFFFB, 32'h02020202, 16'h0000, -1, 8};
    // x={3,0,0,0}: pass0 w={1,0,0,0},b=-3 -> 0; pass1 w=-2,b=5 -> -1
    vecs[1] = '{16'h0003, 32'h00000001, 16'hFFFD, 32'hFEFEFEFE, 16'h0005, 0, -1};
    // x=15: pass0 w=-128,b=-32768 -> -40448; pass1 w=127,b=32767 -> 40387
    vecs[2] = '{16'hFFFF, 32'h80808080, 16'h8000, 32'h7F7F7F7F, 16'h7FFF, -40448, 40387};
    // x={2,7,0,15}: pass0 w={3,-4,100,-1},b=10 -> -27; pass1 w={-5,2,-9,1},b=-1 -> 18
    vecs[3] = '{16'hF072, 32'hFF64FC03, 16'h000A, 32'h01F702FB, 16'hFFFF, -27, 18};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.features = '0;
    bus.weight   = '0;
    bus.bia      = '0;
    repeat (3) @(negedge clk);
    chk("reset in_ready", longint'(bus.in_ready), 1);
    chk("reset svmready", longint'(bus.svmready), 0);
    chk("reset w_class", longint'(bus.w_class), 0);
    chk("reset score", score_s(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle in_ready", longint'(bus.in_ready), 1);
    chk("idle svmready", longint'(bus.svmready), 0);

    for (int i = 0; i < 4; i++) begin
      do_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));
    end

    // Back-to-back: in_valid held high, the next vector is taken at the in_ready edge.
    do_vec(vecs[0], 1'b1, "b2b");
    @(negedge clk);
    chk("b2b second accepted", longint'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    n_sv = 0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (bus.svmready) n_sv++;
    end
    chk("b2b second pass0 pulse", longint'(n_sv), 1);

    // Reset during pass-1 accumulation aborts with no result pulse.
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", longint'(bus.in_ready), 1);
    chk("midrst score", score_s(), 0);
    n_sv = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.svmready) n_sv++;
    end
    chk("midrst no svmready", longint'(n_sv), 0);
    chk("midrst idle", longint'(bus.in_ready), 1);

    do_vec(vecs[3], 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
